// File: rtl/adaptive_pkg.sv
// Shared types and helpers for the adaptive filter and its weight readback path.
// Defaults match the filter build; clog2_min1 keeps index buses at least one bit wide.
package adaptive_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int TAPS_DEF  = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/weight_stream_tx_if.sv
// Weight beat stream: one tap per beat with its index, last marker and overflow flag.
// Master drives the beat fields and valid; slave returns ready.
interface weight_stream_tx_if #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 3
);
    logic [WIDTH-1:0] o_tdata;
    logic [IDXW-1:0]  o_tindex;
    logic             o_tlast;
    logic             o_tovr;
    logic             o_tvalid;
    logic             i_tready;

    modport master (
        output o_tdata, o_tindex, o_tlast, o_tovr, o_tvalid,
        input  i_tready
    );

    modport slave (
        input  o_tdata, o_tindex, o_tlast, o_tovr, o_tvalid,
        output i_tready
    );
endinterface

// File: rtl/period_ticker.sv
// Free-running modulo counter emitting a tick when it reaches period-1; period 0 disables it.
// Latency: tick is combinational from the counter state and the current period.
// Backpressure: none, the tick is a pulse and is never held.
module period_ticker (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_period,
    output logic        o_tick
);
    logic [15:0] count_q, count_d;

    always_comb begin
        o_tick  = 1'b0;
        count_d = count_q;
        if (i_period == 16'd0) begin
            count_d = 16'd0;
        end else if (count_q >= i_period) begin
            // period shrank below the running count: restart silently
            count_d = 16'd0;
        end else if (count_q == 16'(i_period - 16'd1)) begin
            o_tick  = 1'b1;
            count_d = 16'd0;
        end else begin
            count_d = 16'(count_q + 16'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= 16'd0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/weight_stream_tx.sv
// Snapshots the live filter weights on request or periodic tick and streams them one tap per beat.
// Latency: first beat valid one cycle after the trigger; one beat per cycle while ready is high.
// Backpressure: beat held stable while ready is low; triggers arriving mid-snapshot are counted as dropped.
module weight_stream_tx
    import adaptive_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAPS  = TAPS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [TAPS-1:0][WIDTH-1:0]  i_weights,
    input  logic                        i_ovr,
    input  logic                        i_snap_req,
    input  logic [15:0]                 i_auto_period,
    weight_stream_tx_if.master          tx,
    output logic                        o_busy,
    output logic [7:0]                  o_dropped
);
    localparam int IDXW = clog2_min1(TAPS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS - 1);

    tx_state_e                  state_q, state_d;
    logic [TAPS-1:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic                       tovr_q, tovr_d;
    logic                       sticky_q, sticky_d;
    logic [7:0]                 dropped_q, dropped_d;

    logic auto_tick;
    logic trigger, xfer, at_last, capture;

    period_ticker u_ticker (
        .clk      (clk),
        .rst      (rst),
        .i_period (i_auto_period),
        .o_tick   (auto_tick)
    );

    assign trigger = i_snap_req | auto_tick;
    assign xfer    = (state_q == SEND) & tx.i_tready;
    assign at_last = (idx_q == LAST_IDX);
    // a trigger landing on the final handshake chains straight into the next snapshot
    assign capture = ((state_q == IDLE) & trigger) | (xfer & at_last & trigger);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        tovr_d    = tovr_q;
        sticky_d  = sticky_q | i_ovr;
        dropped_d = dropped_q;

        if (capture) begin
            state_d  = SEND;
            shadow_d = i_weights;
            idx_d    = '0;
            tovr_d   = sticky_q | i_ovr;
            sticky_d = i_ovr;
        end else begin
            if (xfer) begin
                if (at_last) state_d = IDLE;
                else         idx_d   = IDXW'(idx_q + 1'b1);
            end
            if ((state_q == SEND) & trigger & (dropped_q != 8'hFF)) begin
                dropped_d = 8'(dropped_q + 8'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            tovr_q    <= 1'b0;
            sticky_q  <= 1'b0;
            dropped_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            tovr_q    <= tovr_d;
            sticky_q  <= sticky_d;
            dropped_q <= dropped_d;
        end
    end

    assign tx.o_tvalid = (state_q == SEND);
    assign tx.o_tdata  = shadow_q[idx_q];
    assign tx.o_tindex = idx_q;
    assign tx.o_tlast  = (state_q == SEND) & at_last;
    assign tx.o_tovr   = tovr_q;
    assign o_busy      = (state_q == SEND);
    assign o_dropped   = dropped_q;
endmodule

// File: tb/tb_weight_stream_tx.sv
// Directed bench for weight_stream_tx with TAPS=8, WIDTH=16; expected values are hand-derived.
// Inputs change 1 time unit after the rising edge, outputs are sampled at that same point.
module tb_weight_stream_tx;
    localparam int WIDTH = 16;
    localparam int TAPS  = 8;
    localparam int IDXW  = 3;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [TAPS-1:0][WIDTH-1:0] i_weights;
    logic                       i_ovr;
    logic                       i_snap_req;
    logic [15:0]                i_auto_period;
    logic                       o_busy;
    logic [7:0]                 o_dropped;

    int n_vec  = 0;
    int n_miss = 0;

    weight_stream_tx_if #(.WIDTH(WIDTH), .IDXW(IDXW)) s_if ();

    weight_stream_tx #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_weights     (i_weights),
        .i_ovr         (i_ovr),
        .i_snap_req    (i_snap_req),
        .i_auto_period (i_auto_period),
        .tx            (s_if.master),
        .o_busy        (o_busy),
        .o_dropped     (o_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic [15:0] base, input logic [15:0] step);
        for (int k = 0; k < TAPS; k++) i_weights[k] = 16'(base + k * step);
    endtask

    // request a snapshot and consume it at full rate, checking every beat
    task automatic send_snap(input logic [15:0] base, input logic [15:0] step,
                             input logic exp_ovr, input logic ovr_at_cap);
        load_weights(base, step);
        i_snap_req     = 1'b1;
        i_ovr          = ovr_at_cap;
        s_if.i_tready  = 1'b1;
        tick();
        i_snap_req = 1'b0;
        i_ovr      = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            chk("snap_vld",  32'(s_if.o_tvalid), 32'd1);
            chk("snap_busy", 32'(o_busy), 32'd1);
            chk("snap_idx",  32'(s_if.o_tindex), 32'(k));
            chk("snap_dat",  32'(s_if.o_tdata), 32'(16'(base + k * step)));
            chk("snap_last", 32'(s_if.o_tlast), 32'(k == TAPS - 1));
            chk("snap_ovr",  32'(s_if.o_tovr), 32'(exp_ovr));
            tick();
        end
        chk("snap_end_vld",  32'(s_if.o_tvalid), 32'd0);
        chk("snap_end_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        i_snap_req    = 1'b0;
        s_if.i_tready = 1'b1;
        while (s_if.o_tvalid && guard < 20) begin
            tick();
            guard++;
        end
        chk("drain_idle", 32'(s_if.o_tvalid), 32'd0);
    endtask

    initial begin
        int exp_k;
        int starts[$];
        logic prev_vld;

        i_weights     = '0;
        i_ovr         = 1'b0;
        i_snap_req    = 1'b0;
        i_auto_period = 16'd0;
        s_if.i_tready = 1'b0;

        #1 rst = 1'b1;
        #2;
        chk("rst_vld",   32'(s_if.o_tvalid), 32'd0);
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_last",  32'(s_if.o_tlast), 32'd0);
        chk("rst_ovr",   32'(s_if.o_tovr), 32'd0);
        chk("rst_dat",   32'(s_if.o_tdata), 32'd0);
        chk("rst_idx",   32'(s_if.o_tindex), 32'd0);
        chk("rst_drop",  32'(o_dropped), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // single request, weights k*0x0101
        send_snap(16'h0000, 16'h0101, 1'b0, 1'b0);

        // backpressure with live weights changing every cycle
        load_weights(16'h1000, 16'h0001);
        i_snap_req = 1'b1;
        tick();
        i_snap_req = 1'b0;
        exp_k = 0;
        for (int cyc = 0; cyc < 100 && exp_k < TAPS; cyc++) begin
            i_weights     = {$urandom, $urandom, $urandom, $urandom};
            s_if.i_tready = (cyc % 3 == 0);
            chk("bp_vld", 32'(s_if.o_tvalid), 32'd1);
            chk("bp_idx", 32'(s_if.o_tindex), 32'(exp_k));
            chk("bp_dat", 32'(s_if.o_tdata), 32'(16'h1000 + exp_k));
            if (s_if.o_tvalid && s_if.i_tready) exp_k++;
            tick();
        end
        chk("bp_beats", 32'(exp_k), 32'd8);
        chk("bp_end",   32'(s_if.o_tvalid), 32'd0);

        // request on the final handshake chains without a bubble
        load_weights(16'h2000, 16'h0001);
        s_if.i_tready = 1'b1;
        i_snap_req    = 1'b1;
        tick();
        i_snap_req = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            chk("b2b_a_dat", 32'(s_if.o_tdata), 32'(16'h2000 + k));
            if (k == TAPS - 1) begin
                load_weights(16'h3000, 16'h0001);
                i_snap_req = 1'b1;
            end
            tick();
        end
        i_snap_req = 1'b0;
        chk("b2b_drop", 32'(o_dropped), 32'd0);
        for (int k = 0; k < TAPS; k++) begin
            chk("b2b_b_vld", 32'(s_if.o_tvalid), 32'd1);
            chk("b2b_b_idx", 32'(s_if.o_tindex), 32'(k));
            chk("b2b_b_dat", 32'(s_if.o_tdata), 32'(16'h3000 + k));
            tick();
        end
        chk("b2b_end", 32'(s_if.o_tvalid), 32'd0);

        // mid-snapshot requests are dropped and the counter saturates
        load_weights(16'h0100, 16'h0001);
        i_snap_req = 1'b1;
        tick();
        i_snap_req = 1'b0;
        repeat (3) tick();
        chk("drop_idx3", 32'(s_if.o_tindex), 32'd3);
        i_snap_req = 1'b1;
        tick();
        chk("drop_one",  32'(o_dropped), 32'd1);
        chk("drop_idx4", 32'(s_if.o_tindex), 32'd4);
        s_if.i_tready = 1'b0;
        repeat (300) tick();
        chk("drop_sat",  32'(o_dropped), 32'd255);
        chk("drop_hold", 32'(s_if.o_tindex), 32'd4);
        drain();

        // asynchronous reset in the middle of a flagged snapshot
        i_ovr = 1'b1;
        tick();
        i_ovr = 1'b0;
        i_snap_req = 1'b1;
        tick();
        i_snap_req = 1'b0;
        repeat (3) tick();
        chk("mid_idx3", 32'(s_if.o_tindex), 32'd3);
        chk("mid_ovr",  32'(s_if.o_tovr), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_vld",  32'(s_if.o_tvalid), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_drop", 32'(o_dropped), 32'd0);
        chk("arst_ovr",  32'(s_if.o_tovr), 32'd0);
        #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_idle", 32'(s_if.o_tvalid), 32'd0);
        end

        // sticky overflow capture and retention
        i_ovr = 1'b1;
        tick();
        i_ovr = 1'b0;
        send_snap(16'h4000, 16'h0001, 1'b1, 1'b0);
        send_snap(16'h5000, 16'h0001, 1'b0, 1'b0);
        send_snap(16'h6000, 16'h0001, 1'b1, 1'b1);
        send_snap(16'h7000, 16'h0001, 1'b1, 1'b0);
        send_snap(16'h7800, 16'h0001, 1'b0, 1'b0);

        // periodic snapshots every 20 cycles
        s_if.i_tready = 1'b1;
        i_auto_period = 16'd20;
        prev_vld = s_if.o_tvalid;
        for (int i = 1; i <= 85; i++) begin
            tick();
            if (s_if.o_tvalid && !prev_vld) starts.push_back(i);
            prev_vld = s_if.o_tvalid;
        end
        chk("auto_n", 32'(starts.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("auto_start", (j < starts.size()) ? 32'(starts[j]) : 32'hFFFF_FFFF, 32'(20 * (j + 1)));
        end
        chk("auto_drop", 32'(o_dropped), 32'd0);

        // period 0 disables ticks; the in-flight snapshot completes
        i_auto_period = 16'd0;
        starts.delete();
        prev_vld = s_if.o_tvalid;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (s_if.o_tvalid && !prev_vld) starts.push_back(i);
            prev_vld = s_if.o_tvalid;
        end
        chk("auto_off_n",   32'(starts.size()), 32'd0);
        chk("auto_off_vld", 32'(s_if.o_tvalid), 32'd0);

        // period 5 is shorter than a snapshot: every other tick is dropped
        i_auto_period = 16'd5;
        repeat (50) tick();
        chk("auto5_drop", 32'(o_dropped), 32'd5);
        i_auto_period = 16'd0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
